// File: rtl/ctrl_decode_stage_pkg.sv
// Shared RV32 control definitions: opcodes, mux encodings, the registered
// control word layout and the decode-stage FSM states.
package ctrl_decode_stage_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SWITCH = 7'b1111111;

    localparam logic [6:0] FUN7_MEXT = 7'b0000001;

    // Write-back result source
    localparam logic [1:0] RES_NONE = 2'd0;
    localparam logic [1:0] RES_IMM  = 2'd1;
    localparam logic [1:0] RES_ALU  = 2'd2;
    localparam logic [1:0] RES_LINK = 2'd3;

    // Immediate / wiring format selector
    localparam logic [2:0] WIRE_REG   = 3'd0;
    localparam logic [2:0] WIRE_JAL   = 3'd1;
    localparam logic [2:0] WIRE_STORE = 3'd2;
    localparam logic [2:0] WIRE_UPPER = 3'd3;
    localparam logic [2:0] WIRE_IMM   = 3'd4;

    typedef enum logic [1:0] {
        RUN,
        SW_REQ,
        SW_DONE
    } state_t;

    typedef struct packed {
        logic       d_mem_r;
        logic       d_mem_w;
        logic       jump;
        logic       branch;
        logic       wrten_reg;
        logic       mux_complmnt;
        logic       mux_d_mem;
        logic [1:0] mux_result;
        logic       mux_inp_2;
        logic       mux_inp_1;
        logic [2:0] mux_wire_module;
        logic [3:0] alu_op;
        logic       switch_cache_w;
        logic       illegal;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_SWITCH = '{switch_cache_w: 1'b1, default: '0};

endpackage

// File: rtl/ctrl_decode_comb.sv
// Pure combinational opcode decode into a control word; the switch opcode
// is flagged separately and decodes to an all-zero, legal word.
module ctrl_decode_comb
    import ctrl_decode_stage_pkg::*;
#(
    parameter int ENABLE_MEXT = 0
) (
    input  logic [6:0]  opcode,
    input  logic [2:0]  fun_3,
    input  logic [6:0]  fun_7,
    output ctrl_word_t  dec_word,
    output logic        is_switch
);

    always_comb begin
        dec_word  = '0;
        is_switch = 1'b0;
        case (opcode)
            OP_LUI: begin
                dec_word.wrten_reg       = 1'b1;
                dec_word.mux_d_mem       = 1'b1;
                dec_word.mux_result      = RES_IMM;
                dec_word.mux_wire_module = WIRE_UPPER;
            end
            OP_AUIPC: begin
                dec_word.wrten_reg       = 1'b1;
                dec_word.mux_d_mem       = 1'b1;
                dec_word.mux_result      = RES_ALU;
                dec_word.mux_inp_2       = 1'b1;
                dec_word.mux_inp_1       = 1'b1;
                dec_word.mux_wire_module = WIRE_UPPER;
            end
            OP_JAL: begin
                dec_word.jump            = 1'b1;
                dec_word.wrten_reg       = 1'b1;
                dec_word.mux_d_mem       = 1'b1;
                dec_word.mux_result      = RES_LINK;
                dec_word.mux_inp_2       = 1'b1;
                dec_word.mux_inp_1       = 1'b1;
                dec_word.mux_wire_module = WIRE_JAL;
            end
            OP_JALR: begin
                dec_word.jump            = 1'b1;
                dec_word.wrten_reg       = 1'b1;
                dec_word.mux_d_mem       = 1'b1;
                dec_word.mux_result      = RES_LINK;
                dec_word.mux_inp_2       = 1'b1;
                dec_word.mux_wire_module = WIRE_IMM;
            end
            OP_BRANCH: begin
                dec_word.branch       = 1'b1;
                dec_word.mux_complmnt = 1'b1;
            end
            OP_LOAD: begin
                dec_word.d_mem_r         = 1'b1;
                dec_word.wrten_reg       = 1'b1;
                dec_word.mux_result      = RES_ALU;
                dec_word.mux_inp_2       = 1'b1;
                dec_word.mux_wire_module = WIRE_IMM;
            end
            OP_STORE: begin
                dec_word.d_mem_w         = 1'b1;
                dec_word.mux_result      = RES_ALU;
                dec_word.mux_inp_2       = 1'b1;
                dec_word.mux_wire_module = WIRE_STORE;
            end
            OP_IMM: begin
                dec_word.wrten_reg       = 1'b1;
                dec_word.mux_d_mem       = 1'b1;
                dec_word.mux_result      = RES_ALU;
                dec_word.mux_inp_2       = 1'b1;
                dec_word.mux_wire_module = WIRE_IMM;
                dec_word.alu_op          = {1'b0, fun_3};
            end
            OP_REG: begin
                dec_word.wrten_reg    = 1'b1;
                dec_word.mux_d_mem    = 1'b1;
                dec_word.mux_result   = RES_ALU;
                dec_word.mux_complmnt = fun_7[5];
                dec_word.alu_op       = {1'b0, fun_3};
                // Multiply/divide group uses the extra alu_op bit, never complement
                if (ENABLE_MEXT != 0 && fun_7 == FUN7_MEXT) begin
                    dec_word.mux_complmnt = 1'b0;
                    dec_word.alu_op       = {1'b1, fun_3};
                end
            end
            OP_SWITCH: is_switch = 1'b1;
            default:   dec_word.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_decode_stage.sv
// Decode stage: valid/ready handshake around the opcode decoder, plus a
// small FSM that issues a cache-switch request with an ack timeout.
module ctrl_decode_stage
    import ctrl_decode_stage_pkg::*;
#(
    parameter  int ENABLE_MEXT = 0,
    parameter  int SW_ID_W     = 2,
    parameter  int SW_TIMEOUT  = 64,
    localparam int ALU_OP_W    = (ENABLE_MEXT != 0) ? 4 : 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         instr,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                d_mem_r,
    output logic                d_mem_w,
    output logic                jump,
    output logic                branch,
    output logic                wrten_reg,
    output logic                mux_complmnt,
    output logic                mux_d_mem,
    output logic                mux_inp_2,
    output logic                mux_inp_1,
    output logic                switch_cache_w,
    output logic                illegal,
    output logic [1:0]          mux_result,
    output logic [2:0]          mux_wire_module,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                cache_sw_req,
    output logic [SW_ID_W-1:0]  cache_sw_id,
    input  logic                cache_sw_ack,
    output logic                sw_error
);

    localparam int CNT_W = $clog2(SW_TIMEOUT + 1);

    state_t             state_reg;
    ctrl_word_t         ctrl_reg;
    ctrl_word_t         dec_word;
    logic               is_switch;
    logic               out_valid_reg;
    logic               sw_req_reg;
    logic               sw_error_reg;
    logic [SW_ID_W-1:0] sw_id_reg;
    logic [SW_ID_W-1:0] sw_id_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic               accept;
    logic               unused_bits;

    ctrl_decode_comb #(
        .ENABLE_MEXT (ENABLE_MEXT)
    ) u_decode (
        .opcode    (instr[6:0]),
        .fun_3     (instr[14:12]),
        .fun_7     (instr[31:25]),
        .dec_word  (dec_word),
        .is_switch (is_switch)
    );

    for (genvar gi = 0; gi < SW_ID_W; gi++) begin : g_sw_id
        assign sw_id_next[gi] = instr[7 + gi];
    end

    assign in_ready = (state_reg == RUN) && !flush && (!out_valid_reg || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= RUN;
            ctrl_reg      <= '0;
            out_valid_reg <= 1'b0;
            sw_req_reg    <= 1'b0;
            sw_error_reg  <= 1'b0;
            sw_id_reg     <= '0;
            cnt_reg       <= '0;
        end else if (flush) begin
            state_reg     <= RUN;
            out_valid_reg <= 1'b0;
            sw_req_reg    <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (out_valid_reg && out_ready)
                        out_valid_reg <= 1'b0;
                    if (accept) begin
                        if (is_switch) begin
                            sw_id_reg  <= sw_id_next;
                            cnt_reg    <= CNT_W'(SW_TIMEOUT);
                            sw_req_reg <= 1'b1;
                            state_reg  <= SW_REQ;
                        end else begin
                            ctrl_reg      <= dec_word;
                            out_valid_reg <= 1'b1;
                        end
                    end
                end
                SW_REQ: begin
                    if (out_valid_reg && out_ready)
                        out_valid_reg <= 1'b0;
                    // Ack wins over a timeout landing in the same cycle
                    if (cache_sw_ack) begin
                        sw_req_reg <= 1'b0;
                        cnt_reg    <= '0;
                        state_reg  <= SW_DONE;
                    end else if (cnt_reg <= CNT_W'(1)) begin
                        sw_req_reg   <= 1'b0;
                        sw_error_reg <= 1'b1;
                        cnt_reg      <= '0;
                        state_reg    <= RUN;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                SW_DONE: begin
                    if (!out_valid_reg || out_ready) begin
                        ctrl_reg      <= CTRL_SWITCH;
                        out_valid_reg <= 1'b1;
                        state_reg     <= RUN;
                    end
                end
                default: state_reg <= RUN;
            endcase
        end
    end

    assign out_valid       = out_valid_reg;
    assign cache_sw_req    = sw_req_reg;
    assign cache_sw_id     = sw_id_reg;
    assign sw_error        = sw_error_reg;
    assign d_mem_r         = ctrl_reg.d_mem_r;
    assign d_mem_w         = ctrl_reg.d_mem_w;
    assign jump            = ctrl_reg.jump;
    assign branch          = ctrl_reg.branch;
    assign wrten_reg       = ctrl_reg.wrten_reg;
    assign mux_complmnt    = ctrl_reg.mux_complmnt;
    assign mux_d_mem       = ctrl_reg.mux_d_mem;
    assign mux_result      = ctrl_reg.mux_result;
    assign mux_inp_2       = ctrl_reg.mux_inp_2;
    assign mux_inp_1       = ctrl_reg.mux_inp_1;
    assign mux_wire_module = ctrl_reg.mux_wire_module;
    assign alu_op          = ctrl_reg.alu_op[ALU_OP_W-1:0];
    assign switch_cache_w  = ctrl_reg.switch_cache_w;
    assign illegal         = ctrl_reg.illegal;

    // Instruction fields outside the decoded ranges are intentionally ignored
    assign unused_bits = ^{instr, ctrl_reg.alu_op, dec_word.alu_op};

endmodule

// File: doc/ctrl_decode_stage.md
CTRL_DECODE_STAGE -- requirements
Module: ctrl_decode_stage

Interface
REQ-001 Parameter ENABLE_MEXT, default 0, SHALL enable RV32M decode when 1.
REQ-002 Parameter SW_ID_W, default 2, SHALL set the cache-switch target id width (1..5).
REQ-003 Parameter SW_TIMEOUT, default 64, SHALL set the cycles the block waits for cache_sw_ack before aborting.
REQ-004 Derived constant ALU_OP_W SHALL equal 4 when ENABLE_MEXT=1, else 3.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 in_valid / in_ready  in / out  1 each  instruction handshake.
REQ-008 instr  in  32  instruction; opcode=[6:0], fun_3=[14:12], fun_7=[31:25], sw id=[6+SW_ID_W:7].
REQ-009 flush  in  1  discards held output and aborts any switch.
REQ-010 out_valid / out_ready  out / in  1 each  control-word handshake.
REQ-011 Registered outputs SHALL be: d_mem_r, d_mem_w, jump, branch, wrten_reg, mux_complmnt, mux_d_mem, mux_inp_2, mux_inp_1, switch_cache_w, illegal (1 each); mux_result (2); mux_wire_module (3); alu_op (ALU_OP_W).
REQ-012 cache_sw_req  out  1; cache_sw_id  out  SW_ID_W; cache_sw_ack  in  1; sw_error  out  1 (sticky).

Function
REQ-013 Control word tuple order SHALL be (d_mem_r,d_mem_w,jump,branch,wrten_reg,mux_complmnt,mux_d_mem,mux_result,mux_inp_2,mux_inp_1,mux_wire_module,alu_op).
REQ-014 Decode SHALL be: 0110111=(0,0,0,0,1,0,1,1,0,0,3,0); 0010111=(0,0,0,0,1,0,1,2,1,1,3,0); 1101111=(0,0,1,0,1,0,1,3,1,1,1,0); 1100111=(0,0,1,0,1,0,1,3,1,0,4,0); 1100011=(0,0,0,1,0,1,0,0,0,0,0,0); 0000011=(1,0,0,0,1,0,0,2,1,0,4,0); 0100011=(0,1,0,0,0,0,0,2,1,0,2,0); 0010011=(0,0,0,0,1,0,1,2,1,0,4,fun_3); 0110011=(0,0,0,0,1,fun_7[5],1,2,0,0,0,fun_3).
REQ-015 alu_op SHALL be zero-extended fun_3 when ALU_OP_W=4, except opcode 0110011 with fun_7=0000001 and ENABLE_MEXT=1, which SHALL give alu_op={1,fun_3} and mux_complmnt=0.
REQ-016 Any other opcode except 1111111 SHALL give an all-zero control word with illegal=1; illegal SHALL be 0 otherwise.
REQ-017 FSM states SHALL be RUN, SW_REQ, SW_DONE.
REQ-018 In RUN, in_ready SHALL equal (!out_valid || out_ready); an accepted non-switch instruction SHALL appear registered with out_valid=1 the next cycle (latency 1).
REQ-019 Accepting opcode 1111111 in RUN SHALL latch cache_sw_id, go to SW_REQ, and load the timeout counter with SW_TIMEOUT.
REQ-020 In SW_REQ, cache_sw_req SHALL be 1 and in_ready 0; the counter SHALL decrement each cycle without ack.
REQ-021 cache_sw_ack=1 in SW_REQ SHALL move to SW_DONE; counter reaching 0 first SHALL set sw_error and return to RUN with no output.
REQ-022 In SW_DONE, once out_valid is 0 or out_ready is 1, the block SHALL load an all-zero control word with switch_cache_w=1, out_valid=1, and return to RUN.
REQ-023 Ack and timeout in the same cycle SHALL resolve as ack (no sw_error).
REQ-024 Output register SHALL hold its value while out_valid=1 and out_ready=0.
REQ-025 flush SHALL clear out_valid, deassert cache_sw_req, and force RUN next cycle; in_ready SHALL be 0 during the flush cycle; flush has priority over all events.
REQ-026 sw_error SHALL clear only on reset.

Reset
REQ-027 Asserting reset SHALL immediately, including mid-switch, force RUN, out_valid=0, cache_sw_req=0, sw_error=0, cache_sw_id=0, counter=0, all control outputs 0.

Structure
REQ-028 Opcode constants, mux_wire_module/mux_result encodings, and the FSM state enum SHALL live in the shared rv32 control package.
REQ-029 Combinational decode SHALL be one sub-module, ctrl_decode_comb, instantiated once; the FSM and output register SHALL be in ctrl_decode_stage.

Verification
REQ-030 Send 0x00C58533 (add) then 0x40C58533 (sub) with out_ready=1 -> cycles 1 and 2 give wrten_reg=1, mux_result=2, alu_op=0, mux_complmnt 0 then 1.
REQ-031 Send LW 0x0002A303 with out_ready=0 for 3 cycles -> d_mem_r=1 held stable, in_ready=0 for those cycles.
REQ-032 Send 0x000001FF with SW_ID_W=2, ack on the 3rd req cycle -> cache_sw_id=3, then one output with switch_cache_w=1, then in_ready=1.
REQ-033 Switch with SW_TIMEOUT=4 and no ack -> req high for 4 cycles, sw_error=1, no output.
REQ-034 ENABLE_MEXT=1, send 0x02C58533 (mul) -> alu_op=4'b1000; opcode 0x0000000B -> illegal=1, wrten_reg=0.
REQ-035 Assert flush, then separately reset, during SW_REQ -> req drops; RUN resumes; sw_error unchanged after flush and cleared after reset.
